// File: rtl/mem_initiator.sv
// mem_initiator: bus initiator for the single-port Memory block.
// Accepts single/burst read or write commands on a valid/ready channel and
// drives Memory's re/we/Address plus the shared tri-state Data bus. Read
// words return on a registered response channel with backpressure.
//
// Ports:
//   clock, reset_L                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_write/addr/len/wdata       command payload (burst = cmd_len+1 words)
//   rsp_valid/rsp_ready            response handshake
//   rsp_data/rsp_last              read word and end-of-burst flag
//   busy                           engine not idle
//   mem_re/mem_we/mem_addr         Memory control
//   mem_data                       shared tri-state data bus
//
// Build option: define MEM_INITIATOR_RAMP_EN to make write bursts store an
// incrementing ramp starting at cmd_wdata instead of a constant fill.
module mem_initiator #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8,
  parameter int unsigned LW = 4
) (
  input  logic          clock,
  input  logic          reset_L,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic          busy,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  inout  wire  [DW-1:0] mem_data
);

  typedef enum logic [1:0] {IDLE, TURN, WRITE, READ} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          write_q, write_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_last_q, rsp_last_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          busy_q, busy_d;
  logic          mem_re_q, mem_re_d;
  logic          mem_we_q, mem_we_d;

  // State and registered outputs
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
    end
  end

  // Next-state logic; output registers are decoded from the next state
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;

    // Consumer took the word; a beat captured this edge overrides below
    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          rem_d   = cmd_len;
          wdata_d = cmd_wdata;
          write_d = cmd_write;
          state_d = TURN;
        end
      end
      TURN: state_d = write_q ? WRITE : READ;
      WRITE: begin
        addr_d = addr_q + AW'(1);
        rem_d  = rem_q - LW'(1);
`ifdef MEM_INITIATOR_RAMP_EN
        wdata_d = wdata_q + DW'(1);
`else
        wdata_d = wdata_q;
`endif
        if (rem_q == '0) state_d = IDLE;
      end
      READ: begin
        // Beat only when the single response slot is free
        if (!rsp_valid_q || rsp_ready) begin
          rsp_data_d  = mem_data;
          rsp_valid_d = 1'b1;
          rsp_last_d  = (rem_q == '0);
          addr_d      = addr_q + AW'(1);
          rem_d       = rem_q - LW'(1);
          if (rem_q == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    mem_we_d    = (state_d == WRITE);
    mem_re_d    = (state_d == READ);
    cmd_ready_d = (state_d == IDLE) && !rsp_valid_d;
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign busy      = busy_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;

  // Bus driven only while writing; released asynchronously by reset
  assign mem_data = mem_we_q ? wdata_q : {DW{1'bz}};

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- Bus initiator for the single-port `Memory` block: it drives re/we/Address and the shared tri-state Data bus.
- Upstream logic issues single or burst read/write commands over a valid/ready interface. Read data returns on a registered response channel with backpressure.
- Write bursts fill consecutive addresses with one value.
- Sits between the datapath/controller and `Memory`. It is the only other driver of Memory's Data bus.

Parameters:
- DW, 8, data width; matches Memory DW.
- AW, 8, address width; matches Memory AW.
- LW, 4, burst-length field width; a burst is cmd_len+1 words (1..2**LW).

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset_L  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at posedge.
- cmd_write  input  1  1 = write burst, 0 = read burst.
- cmd_addr  input  AW  start address.
- cmd_len  input  LW  word count minus one.
- cmd_wdata  input  DW  write value.
- rsp_valid  output  1  read word available.
- rsp_ready  input  1  consumer takes the word when rsp_valid & rsp_ready at posedge.
- rsp_data  output  DW  read word.
- rsp_last  output  1  rsp_data is the final word of the burst.
- busy  output  1  state != IDLE.
- mem_re  output  1  to Memory re.
- mem_we  output  1  to Memory we.
- mem_addr  output  AW  to Memory Address.
- mem_data  inout  DW  tri-state, shared with Memory Data.

Behaviour:
- Reset values (asynchronous, immediate):
  - state = IDLE.
  - cmd_ready = 0 while reset_L is low. After release, cmd_ready follows the IDLE rule below.
  - rsp_valid = rsp_last = 0, rsp_data = 0, busy = 0.
  - mem_re = mem_we = 0, mem_addr = 0.
  - mem_data released to high-Z at once.
- Reset mid-burst: the burst is abandoned, no further beats occur, and any pending response is dropped.
- States are IDLE, TURN, WRITE, READ.
- IDLE:
  - cmd_ready = !rsp_valid.
  - On accept, latch addr, len, wdata and write, then go to TURN.
- TURN:
  - Exactly one cycle with mem_re = mem_we = 0 and mem_data high-Z (bus turnaround).
  - Next state is WRITE if write is set, else READ.
- WRITE:
  - mem_we = 1, mem_addr = addr, and mem_data driven with the write value for every cycle in WRITE.
  - Memory captures one word per posedge.
  - Each cycle: addr <= addr+1 mod 2**AW and remaining-1. After the final beat, go to IDLE.
  - A write burst lasts 1 (accept) + 1 (TURN) + (len+1) cycles.
- READ:
  - mem_re = 1 and mem_addr = addr. mem_data is never driven by this block.
  - A beat fires on a posedge when the response slot is free, i.e. !rsp_valid | rsp_ready.
  - On a beat: rsp_data <= mem_data, rsp_valid <= 1, rsp_last <= (remaining == 0), addr increments, remaining decrements.
  - After the final beat, go to IDLE.
  - If the response slot is not free, the beat stalls: mem_re and mem_addr hold, and nothing advances.
  - Read latency is one cycle: a word is visible on rsp_* the cycle after its address is on the bus.
- Response handshake:
  - rsp_valid clears on rsp_valid & rsp_ready when no new beat is captured that edge.
  - rsp_data and rsp_last hold stable while rsp_valid & !rsp_ready.
- Mutual exclusion (invariant): mem_re and mem_we are never both 1. mem_data is driven only in WRITE, and mem_re = 0 there.
- Boundaries:
  - Address wraps from 2**AW-1 to 0 with no error.
  - cmd_len = 2**LW-1 gives a maximum burst of 2**LW words.
  - cmd_valid held high while not ready has no effect, and command inputs are ignored while busy.
  - A new command cannot be accepted until the last response is consumed.

Optional Feature:
- Macro: MEM_INITIATOR_RAMP_EN.
- Defined: in WRITE, the driven data increments by 1 per beat (mod 2**DW), starting at cmd_wdata. Bursts therefore write a ramp.
- Undefined: every beat of a write burst writes cmd_wdata unchanged.

Test Plan:
- Single write: write=1, addr=0x10, len=0, wdata=0xA5.
  - mem_we high exactly 1 cycle, 2 cycles after accept, with mem_addr=0x10 and mem_data=0xA5.
  - Memory M[0x10]=0xA5.
  - busy returns to 0.
- Burst read with rsp_ready=1:
  - Preload M[0x20..0x23] = 1,2,3,4; command addr=0x20, len=3.
  - rsp_valid high on 4 consecutive cycles with rsp_data 1,2,3,4.
  - rsp_last only on 4.
  - mem_re never coincides with mem_we.
- Backpressure:
  - Same read with rsp_ready held 0 for 3 cycles after the first word.
  - rsp_data holds 1, and mem_addr holds 0x21 during the stall.
  - All 4 words are delivered in order with none lost or duplicated.
- Wrap fill:
  - write=1, addr=0xFE, len=3, wdata=0x3C.
  - Writes land at 0xFE, 0xFF, 0x00, 0x01 (with ramp: 0x3C, 0x3D, 0x3E, 0x3F).
- Reset mid-burst:
  - Assert reset_L=0 during the second beat of a 4-word write.
  - mem_we=0 and mem_data=Z immediately; M at the 3rd and 4th addresses unchanged.
  - After release, cmd_ready=1.
- Turnaround:
  - A write then an immediate read.
  - At least one cycle with mem_re=mem_we=0 and mem_data=Z between the last write beat and the first read beat.
